spi_tuning_rx: RTL
==================

# spi_tuning_rx

SPI slave front end that receives voice tuning updates from the host MCU and feeds them to the DDS phase-accumulator block. It deframes 40-bit SPI frames (8-bit voice index + 32-bit tuning code) and buffers them in a small FIFO. Updates are released to the DDS as single-cycle `o_SPI_flag` strobes, paced to one per voice pipeline round, so the DDS single-entry update buffer never drops an update.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of buffered updates; power of two, ≥2.
- `SYNC_STAGES`, default 2: synchronizer flops on each SPI input.

Ports:
- `i_clk`, in, 1: system clock. One clock domain for the whole block.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_sclk`, in, 1: SPI clock, asynchronous to `i_clk`. Mode 0.
- `i_mosi`, in, 1: SPI data, MSB first.
- `i_cs_n`, in, 1: SPI chip select, active-low.
- `i_pipeline_state`, in, 2: DDS voice pipeline phase. Cycles 0→1→2.
- `o_SPI_flag`, out, 1: one-cycle strobe; update valid.
- `o_SPI_tuning_code`, out, 32: delta-phase word for the DDS.
- `o_SPI_voice_index`, out, 8: target voice.
- `o_frame_err`, out, 1: one-cycle pulse when a frame is discarded for a bad length.
- `o_overflow`, out, 1: one-cycle pulse when a good frame is dropped because the FIFO is full.

## Operation
- Input conditioning:
  - `i_sclk`, `i_mosi` and `i_cs_n` each pass through a `SYNC_STAGES` synchronizer.
  - Edges are detected on the synchronized copies.
  - `i_clk` frequency must be at least 4× `i_sclk`.
- Receive FSM states:
  - **WAIT_IDLE**:
    - Entered on reset.
    - Leaves for IDLE when synchronized cs_n is high.
    - Purpose: a frame already in progress at reset release is never partially accepted.
  - **IDLE**:
    - On a cs_n falling edge: clear the shift register and bit counter, then go to SHIFT.
  - **SHIFT**:
    - On each sclk rising edge: shift mosi in at the LSB and increment the counter. The counter saturates at 41.
    - On a cs_n rising edge: go to COMMIT.
  - **COMMIT** (one cycle):
    - Counter == 40: push {shift[39:32] → voice index, shift[31:0] → tuning code} into the FIFO. If the FIFO is full, do not push; pulse `o_overflow`.
    - Otherwise: discard the frame and pulse `o_frame_err`. This covers 0–39 bits and more than 40 bits.
    - Next state is IDLE.
- A cs_n falling edge in COMMIT or WAIT_IDLE is ignored; that frame is lost without an error pulse.
- Drain:
  - Condition: `i_pipeline_state == 2'd0` is sampled at a clock edge and the FIFO is non-empty.
  - At that edge: pop the head into the output registers and set `o_SPI_flag` for the following cycle only.
  - This yields at most one strobe per pipeline round. The DDS frees its buffer in state 2 before the next strobe arrives.
- `o_SPI_tuning_code` and `o_SPI_voice_index` hold the last popped value until the next pop.
- Push and pop in the same cycle is legal at any occupancy, including full: the pop frees a slot and the push is accepted.
- FIFO order is strict FIFO. Pointer arithmetic is modulo `FIFO_DEPTH`, with an extra wrap bit for full/empty detection.

## Timing
- Reset values:
  - `o_SPI_flag`, `o_frame_err`, `o_overflow`: 0.
  - `o_SPI_tuning_code`: 32'h0. `o_SPI_voice_index`: 8'h0.
  - FIFO empty. FSM in WAIT_IDLE.
- Reset takes effect on the first clock edge with `i_reset` high. It aborts any frame in progress and flushes the FIFO without emitting strobes.
- Latency from raw `i_cs_n` rising to FIFO push: `SYNC_STAGES` + 2 cycles (edge detect, COMMIT).
- Latency from push into an empty FIFO to `o_SPI_flag`: up to 3 cycles, waiting for the next state-0 edge.
- `o_SPI_flag` is never high on two consecutive cycles. Minimum spacing equals the pipeline round length.
- Error and overflow pulses are one cycle wide, in the cycle after COMMIT.

## Structure
- Shared package `midisynth_pkg`:
  - `FRAME_BITS = 40`
  - `VOICE_W = 8`
  - `TUNING_W = 32`
  - `PIPE_READ = 2'd0`, `PIPE_COMPUTE = 2'd1`, `PIPE_UPDATE = 2'd2`
  - FSM state enum
- Sub-module `update_fifo`: synchronous FIFO, 40-bit wide, `FIFO_DEPTH` deep. Ports: push, pop, din, dout, full, empty.
- Synchronizers and the FSM are inline in `spi_tuning_rx`.

## Test plan
- **Single frame:** voice 8'h05, code 32'h12345678 at sclk = clk/8. Expect exactly one `o_SPI_flag`, in the cycle after a state-0 edge, with outputs 05 / 12345678.
- **Burst:** 4 back-to-back frames (voices 1–4) sent while `i_pipeline_state` cycles. Expect 4 strobes in order, spaced ≥3 cycles apart. `o_overflow` stays 0.
- **Overflow:** hold `i_pipeline_state` at 2'd1 and send 5 frames. Expect `o_overflow` to pulse once on the 5th. On releasing the pipeline, expect strobes for frames 1–4 only.
- **Length errors:**
  - 39-bit frame → `o_frame_err` pulse, no push.
  - 41-bit frame → `o_frame_err` pulse, no push.
  - Following 40-bit frame → accepted normally.
- **Reset mid-frame:** assert `i_reset` after 20 bits and release while cs_n is still low. Expect the remaining bits to be ignored, no strobe and no error. The next full frame is accepted.
- **Simultaneous push and pop at full:** COMMIT coincides with a state-0 pop. Expect no overflow and correct ordering of all 5 frames.

Source files
------------

// File: rtl/midisynth_pkg.sv
// ============================================================================
//  midisynth_pkg
//  Shared widths, pipeline phase codes and receive FSM encoding for the
//  synth control path.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package midisynth_pkg;

  localparam int FRAME_BITS = 40;
  localparam int VOICE_W    = 8;
  localparam int TUNING_W   = 32;

  localparam logic [1:0] PIPE_READ    = 2'd0;
  localparam logic [1:0] PIPE_COMPUTE = 2'd1;
  localparam logic [1:0] PIPE_UPDATE  = 2'd2;

  // Bit counter saturates one past a legal frame so over-long frames stay distinguishable.
  localparam int          CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_FULL = 6'd40;
  localparam logic [CNT_W-1:0] CNT_SAT  = 6'd41;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_COMMIT    = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [VOICE_W-1:0]  voice;
    logic [TUNING_W-1:0] code;
  } tuning_upd_t;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_SAT) ? cnt : cnt + 6'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/update_fifo.sv
// ============================================================================
//  update_fifo
//  Synchronous FIFO for tuning updates; pointers carry an extra wrap bit.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module update_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot the push lands in, so full+pop still accepts.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || i_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
  end

endmodule

`default_nettype wire

// File: rtl/spi_tuning_rx.sv
// ============================================================================
//  spi_tuning_rx
//  SPI mode-0 slave deframing 40-bit voice tuning updates, buffered and
//  released to the DDS as one strobe per voice pipeline round.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_tuning_rx
  import midisynth_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_sclk,
  input  logic                i_mosi,
  input  logic                i_cs_n,
  input  logic [1:0]          i_pipeline_state,
  output logic                o_SPI_flag,
  output logic [TUNING_W-1:0] o_SPI_tuning_code,
  output logic [VOICE_W-1:0]  o_SPI_voice_index,
  output logic                o_frame_err,
  output logic                o_overflow
);

  // Lane order inside each synchronizer stage: {cs_n, mosi, sclk}.
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_prev_q;
  logic [2:0] sync_now;

  logic sclk_rise;
  logic cs_s;
  logic cs_fall;
  logic cs_rise;
  logic mosi_s;

  rx_state_e state_q, state_d;

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic start_frame;
  logic shift_en;
  logic frame_ok;
  logic frame_bad;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        drop_full;
  tuning_upd_t fifo_head;
  logic [FRAME_BITS-1:0] fifo_dout;

  logic                flag_q;
  logic                err_q;
  logic                ovf_q;
  logic [TUNING_W-1:0] code_q;
  logic [VOICE_W-1:0]  voice_q;

  // Synchronizers reset low so a chip select held low across reset never looks like an edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
      sync_prev_q <= 3'b000;
    end else begin
      sync_q[0] <= {i_cs_n, i_mosi, i_sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_now  = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sync_now[0] && !sync_prev_q[0];
  assign mosi_s    = sync_now[1];
  assign cs_s      = sync_now[2];
  assign cs_fall   = !sync_now[2] && sync_prev_q[2];
  assign cs_rise   = sync_now[2] && !sync_prev_q[2];

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_WAIT_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_IDLE: if (cs_s)    state_d = ST_IDLE;
      ST_IDLE:      if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT:     if (cs_rise) state_d = ST_COMMIT;
      ST_COMMIT:                 state_d = ST_IDLE;
      default:                   state_d = ST_WAIT_IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    shift_en    = 1'b0;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    unique case (state_q)
      ST_IDLE:   start_frame = cs_fall;
      ST_SHIFT:  shift_en    = sclk_rise;
      ST_COMMIT: begin
        frame_ok  = (cnt_q == CNT_FULL);
        frame_bad = (cnt_q != CNT_FULL);
      end
      default: ;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (start_frame) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
      cnt_d   = cnt_step(cnt_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_pop  = (i_pipeline_state == PIPE_READ) && !fifo_empty;
  assign fifo_push = frame_ok && (!fifo_full || fifo_pop);
  assign drop_full = frame_ok && fifo_full && !fifo_pop;
  assign fifo_head = fifo_dout;

  update_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_din   (shift_q),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      code_q  <= '0;
      voice_q <= '0;
    end else begin
      flag_q <= fifo_pop;
      err_q  <= frame_bad;
      ovf_q  <= drop_full;
      if (fifo_pop) begin
        code_q  <= fifo_head.code;
        voice_q <= fifo_head.voice;
      end
    end
  end

  assign o_SPI_flag        = flag_q;
  assign o_SPI_tuning_code = code_q;
  assign o_SPI_voice_index = voice_q;
  assign o_frame_err       = err_q;
  assign o_overflow        = ovf_q;

endmodule

`default_nettype wire
